debug_uart_arbiter: RTL
=======================

DEBUG_UART_ARBITER -- requirements
Module: debug_uart_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, CPU byte FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter GUARD_CYCLES, default 2, maximum cycles to wait for tx_busy to rise after a start.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_wr  input  1  one-cycle CPU write strobe.
REQ-006 SHALL have port cpu_data  input  8  CPU byte, sampled when cpu_wr=1.
REQ-007 SHALL have port evt_valid  input  1  debug event source has a byte.
REQ-008 SHALL have port evt_data  input  8  event byte, stable while evt_valid=1.
REQ-009 SHALL have port evt_ready  output  1  one-cycle pulse, event byte accepted.
REQ-010 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-011 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-012 SHALL have port tx_start  output  1  registered one-cycle UART start pulse.
REQ-013 SHALL have port tx_data  output  8  registered byte to transmit, held until the next grant.
REQ-014 SHALL have port fifo_full  output  1  FIFO count equals FIFO_DEPTH.
REQ-015 SHALL have port fifo_level  output  5  current FIFO count, 0..FIFO_DEPTH.
REQ-016 SHALL have port overflow  output  1  sticky flag, a CPU byte was dropped.

Function
REQ-017 SHALL accept a CPU write when cpu_wr=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
REQ-018 SHALL drop a cpu_wr arriving at full with no same-cycle pop, leave FIFO contents unchanged and set overflow.
REQ-019 SHALL give ovf_clr priority below a same-cycle overflow event, so the flag stays set.
REQ-020 SHALL use wrapping read and write pointers of log2(FIFO_DEPTH) bits, with count tracked separately so full and empty are unambiguous.
REQ-021 SHALL implement the FSM states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-022 SHALL, in IDLE with tx_busy=0 and any requester pending, grant one requester, register tx_start=1 and tx_data for exactly one cycle, and move to WAIT_BUSY.
REQ-023 SHALL treat the CPU as pending when the FIFO is non-empty and the event source as pending when evt_valid=1.
REQ-024 SHALL pop the FIFO on a CPU grant in the same cycle, and pulse evt_ready on an event grant in the same cycle.
REQ-025 SHALL arbitrate round-robin: with both pending, grant the requester not granted last; last_grant resets to CPU, so the first contended grant goes to the event source.
REQ-026 SHALL, in WAIT_BUSY, move to WAIT_DONE when tx_busy=1, or to IDLE after GUARD_CYCLES cycles without tx_busy.
REQ-027 SHALL, in WAIT_DONE, move to IDLE when tx_busy=0.
REQ-028 SHALL NOT grant while in IDLE with tx_busy=1.
REQ-029 SHALL produce tx_start in the cycle after the FIFO becomes non-empty, given FSM IDLE and tx_busy=0.
REQ-030 SHALL keep tx_start at 0 outside the single grant cycle, and never assert it twice without an intervening IDLE.

Reset
REQ-031 SHALL, on rst_n=0, immediately force: FSM=IDLE; pointers and count=0; tx_start=0; tx_data=0x00; evt_ready=0; overflow=0; last_grant=CPU.
REQ-032 SHALL, on reset mid-transfer, discard all FIFO contents and abandon the in-flight byte with no tx_start after release.
REQ-033 SHALL, after rst_n deasserts, operate from the first rising clk edge with no extra synchronisation delay.

Verification
REQ-034 SHALL pass: cpu_wr 0x41 into empty FIFO, tx_busy=0 -> tx_start=1 with tx_data=0x41 in the next cycle; fifo_level back to 0.
REQ-035 SHALL pass: 5 cpu_wr, FIFO_DEPTH=4, tx_busy=1 throughout -> fifo_level=4, fifo_full=1, overflow=1, 5th byte lost, ovf_clr clears overflow.
REQ-036 SHALL pass: FIFO holds 0x10,0x11, evt_valid with 0x55, UART model busy 10 cycles per byte -> transmit order 0x55, 0x10, 0x11.
REQ-037 SHALL pass: full FIFO, same-cycle grant pop and cpu_wr 0x77 -> 0x77 accepted, overflow stays 0, fifo_level stays 4.
REQ-038 SHALL pass: tx_busy tied 0 after start -> FSM returns to IDLE after 2 cycles, next byte then starts.
REQ-039 SHALL pass: rst_n pulsed low during WAIT_DONE with 3 bytes queued -> fifo_level=0 and no tx_start after release.

Source files
------------

// File: rtl/debug_uart_arbiter_if.sv
// Bus bundle between the debug UART arbiter, the CPU write port, the event source and the UART.
interface debug_uart_arbiter_if;
    logic       cpu_wr;
    logic [7:0] cpu_data;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_ready;
    logic       ovf_clr;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       fifo_full;
    logic [4:0] fifo_level;
    logic       overflow;

    // Arbiter side
    modport slave (
        input  cpu_wr, cpu_data, evt_valid, evt_data, ovf_clr, tx_busy,
        output evt_ready, tx_start, tx_data, fifo_full, fifo_level, overflow
    );

    // Requester / UART side
    modport master (
        output cpu_wr, cpu_data, evt_valid, evt_data, ovf_clr, tx_busy,
        input  evt_ready, tx_start, tx_data, fifo_full, fifo_level, overflow
    );
endinterface

// File: rtl/debug_uart_arbiter.sv
// Shares one UART transmitter between a buffered CPU byte stream and a debug event source.
// CPU bytes go through a small FIFO; the two requesters are served round-robin, one byte
// per start pulse, and the arbiter waits for the UART to go busy and idle again (or for a
// short guard window if busy never rises) before granting the next byte.
module debug_uart_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    debug_uart_arbiter_if.slave   bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [GRD_W-1:0] GUARD_LAST = GRD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // FSM / output registers
    state_t             state_q, state_d;
    logic [GRD_W-1:0]   guard_q, guard_d;
    logic               last_evt_q, last_evt_d;     // 0: CPU granted last, 1: event granted last
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               evt_ready_q, evt_ready_d;

    // FIFO registers
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;

    // Internal strobes
    logic               pop;
    logic               wr_acc;
    logic               cpu_pend;
    logic               evt_pend;
    logic               grant_evt;

    assign cpu_pend = (count_q != '0);
    assign evt_pend = bus.evt_valid;

    // Arbitration and transfer sequencing: next state and registered outputs
    always_comb begin
        state_d     = state_q;
        guard_d     = guard_q;
        last_evt_d  = last_evt_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        evt_ready_d = 1'b0;
        pop         = 1'b0;
        grant_evt   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.tx_busy && (cpu_pend || evt_pend)) begin
                    // With both pending, the one not served last wins.
                    grant_evt  = evt_pend && (!cpu_pend || !last_evt_q);
                    tx_start_d = 1'b1;
                    guard_d    = '0;
                    state_d    = ST_WAIT_BUSY;
                    last_evt_d = grant_evt;
                    if (grant_evt) begin
                        tx_data_d   = bus.evt_data;
                        evt_ready_d = 1'b1;
                    end else begin
                        tx_data_d = mem_q[rd_ptr_q];
                        pop       = 1'b1;
                    end
                end
            end
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (guard_q == GUARD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GRD_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a write at full is only accepted when a pop frees a slot that cycle
    always_comb begin
        wr_acc   = bus.cpu_wr && ((count_q != DEPTH_C) || pop);
        wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (wr_acc && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_acc && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d = (count_d == DEPTH_C);

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (bus.cpu_wr && !wr_acc) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            guard_q     <= '0;
            last_evt_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            evt_ready_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            last_evt_q  <= last_evt_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            evt_ready_q <= evt_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents are discarded on reset by clearing pointers and count
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.cpu_data;
        end
    end

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.evt_ready  = evt_ready_q;
    assign bus.fifo_level = count_q;
    assign bus.fifo_full  = full_q;
    assign bus.overflow   = ovf_q;

endmodule
